jtcps2_obj_copy: RTL
====================

Name: jtcps2_obj_copy

Overview:
Parametrised ORAM-to-frame-buffer copier for the CPS2 object engine. During active video it walks the selected object-table bank in SDRAM, one word per paced slot, and writes each word into the object frame buffer. It toggles the frame-buffer bank once per frame and supports configurable table depth, pacing, bank count and trigger line. Sits between the SDRAM ORAM port and jtcps2_obj's frame buffer.

Parameters:
AW, 12, word-address width of one object-table bank (copy length = 2^AW words)
BW, 1, width of source bank select (2^BW banks in SDRAM)
PACE, 28, pxl_cen ticks between consecutive requests (>=2)
FRAME_LINE, 9'h00E, vdump value that toggles obank_frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pxl_cen  in  1  pixel clock enable
vdump  in  9  current video line
LVBL  in  1  vertical blank, active low
obank  in  BW  requested source bank
oram_addr  out  BW+AW  SDRAM word address {bank_latched, word_cnt}
oram_cs  out  1  SDRAM request, held until accepted
oram_ok  in  1  SDRAM data valid
oram_data  in  16  SDRAM read data
oframe_addr  out  AW  frame-buffer write address
oframe_data  out  16  frame-buffer write data
oframe_we  out  1  frame-buffer write strobe, one cycle per word
obank_frame  out  1  frame-buffer bank in use
busy  out  1  high while a copy is in progress

Behaviour:
- Reset (sync, rst=1): state=IDLE, word_cnt=0, pace_cnt=0, oram_cs=0, oframe_we=0, oframe_addr=0, oframe_data=0, obank_frame=0, busy=0, bank_latched=0.
- obank_frame: toggles on the first clk where vdump==FRAME_LINE (edge of the compare, not level); never toggles twice in one line; independent of copy state.
- FSM states: IDLE, PACE, REQ, WRITE, DONE.
- IDLE: waits for LVBL=1; on entry to active video latches obank into bank_latched, clears word_cnt/pace_cnt, goes to PACE, busy=1.
- PACE: pace_cnt increments on pxl_cen; when pace_cnt==PACE-1 and pxl_cen, clear pace_cnt, go to REQ.
- REQ: oram_cs=1. oram_ok is ignored in the first cycle of REQ (stale-ok guard). On a later oram_ok=1: latch oram_data into oframe_data, oframe_addr<=word_cnt, go to WRITE, oram_cs=0 the next cycle.
- WRITE: oframe_we=1 for exactly one cycle. If word_cnt is all-ones, go to DONE; otherwise word_cnt+1 and return to PACE. No wrap into the next bank.
- DONE: busy=0, oram_cs=0, remains until LVBL=0.
- LVBL=0 in any state: abort to IDLE next cycle, oram_cs=0, oframe_we=0, no write for an in-flight request even if oram_ok arrives the same cycle.
- obank changes mid-copy have no effect until the next active period; the address always uses bank_latched.
- Slot latency: request no sooner than PACE pxl_cen ticks after the previous write; write one cycle after the accepted oram_ok.
- pxl_cen is ignored outside PACE.

Optional Feature:
JTCPS2_OBJ_EARLYEND_EN: when defined, the block checks the attribute word of each 4-word entry (word_cnt[1:0]==3). If oram_data[15:8]==8'hFF, the word is still written, then the FSM goes to DONE, skipping the rest of the table. When undefined, all 2^AW words are always copied regardless of data.

Test Plan:
- Reset mid-REQ with oram_cs=1, rst=1 for 1 cycle -> next cycle oram_cs=0, busy=0, obank_frame=0, oframe_we=0.
- AW=4, PACE=4, oram_ok returned 2 cycles after cs, LVBL high long enough -> exactly 16 oframe_we pulses, addr 0..15, data matches SDRAM model, then busy=0.
- oram_ok already high when REQ is entered -> not accepted in the first REQ cycle; data taken on the following ok cycle.
- obank=0 at copy start, switched to 1 at word 5 -> all oram_addr carry bank bit 0.
- LVBL drops while REQ is pending and oram_ok arrives the same cycle -> no oframe_we; FSM in IDLE; the next frame restarts at word 0.
- vdump steps 13->14->14->15 over two frames -> obank_frame toggles once per frame. With JTCPS2_OBJ_EARLYEND_EN and word 7 = 16'hFF00, copy stops after the 8th write, even with AW=12.

Source files
------------

// File: rtl/jtcps2_obj_copy_if.sv
// Bus bundle between the object-table copier, the SDRAM ORAM read port and the
// object frame-buffer write port.
interface jtcps2_obj_copy_if #(
  parameter int AW = 12,
  parameter int BW = 1
);
  logic [BW+AW-1:0] oram_addr;
  logic             oram_cs;
  logic             oram_ok;
  logic [15:0]      oram_data;
  logic [AW-1:0]    oframe_addr;
  logic [15:0]      oframe_data;
  logic             oframe_we;

  modport master (
    output oram_addr, oram_cs, oframe_addr, oframe_data, oframe_we,
    input  oram_ok, oram_data
  );

  modport slave (
    input  oram_addr, oram_cs, oframe_addr, oframe_data, oframe_we,
    output oram_ok, oram_data
  );
endinterface

// File: rtl/jtcps2_obj_copy.sv
// Paced ORAM -> object frame-buffer copier with per-frame buffer bank toggle.
// Optional JTCPS2_OBJ_EARLYEND_EN: stop after an entry whose attribute high byte is FF.
module jtcps2_obj_copy #(
  parameter int         AW         = 12,
  parameter int         BW         = 1,
  parameter int         PACE       = 28,
  parameter logic [8:0] FRAME_LINE = 9'h00E
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              pxl_cen,
  input  logic [8:0]        vdump,
  input  logic              LVBL,
  input  logic [BW-1:0]     obank,
  jtcps2_obj_copy_if.master bus,
  output logic              obank_frame,
  output logic              busy
);
  localparam int PW = (PACE > 2) ? $clog2(PACE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PACE  = 3'd1,
    ST_REQ   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_q,       state_d;
  logic [AW-1:0] word_cnt_q,    word_cnt_d;
  logic [PW-1:0] pace_cnt_q,    pace_cnt_d;
  logic          req_first_q,   req_first_d;
  logic          oram_cs_q,     oram_cs_d;
  logic          oframe_we_q,   oframe_we_d;
  logic [AW-1:0] oframe_addr_q, oframe_addr_d;
  logic [15:0]   oframe_data_q, oframe_data_d;
  logic          obank_frame_q, obank_frame_d;
  logic          line_hit_q,    line_hit_d;
  logic          busy_q,        busy_d;
  logic [BW-1:0] bank_q,        bank_d;
  logic          last_word;
`ifdef JTCPS2_OBJ_EARLYEND_EN
  logic          early_q,       early_d;
`endif

`ifdef JTCPS2_OBJ_EARLYEND_EN
  assign last_word = (&word_cnt_q) | early_q;
`else
  assign last_word = &word_cnt_q;
`endif

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    pace_cnt_d    = pace_cnt_q;
    req_first_d   = req_first_q;
    oram_cs_d     = oram_cs_q;
    oframe_we_d   = 1'b0;
    oframe_addr_d = oframe_addr_q;
    oframe_data_d = oframe_data_q;
    busy_d        = busy_q;
    bank_d        = bank_q;
`ifdef JTCPS2_OBJ_EARLYEND_EN
    early_d       = early_q;
`endif

    // Frame-buffer bank flips on the rising edge of the line match only.
    line_hit_d    = (vdump == FRAME_LINE);
    obank_frame_d = obank_frame_q ^ (line_hit_d & ~line_hit_q);

    if (!LVBL) begin
      // Blanking kills everything, including a request whose ok lands now.
      state_d   = ST_IDLE;
      oram_cs_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_PACE;
          bank_d     = obank;
          word_cnt_d = '0;
          pace_cnt_d = '0;
          busy_d     = 1'b1;
        end
        ST_PACE: begin
          if (pxl_cen) begin
            if (pace_cnt_q == PW'(PACE - 1)) begin
              pace_cnt_d  = '0;
              state_d     = ST_REQ;
              oram_cs_d   = 1'b1;
              req_first_d = 1'b1;
            end else begin
              pace_cnt_d = pace_cnt_q + PW'(1);
            end
          end
        end
        ST_REQ: begin
          // An ok seen in the first request cycle belongs to someone else.
          req_first_d = 1'b0;
          if (!req_first_q && bus.oram_ok) begin
            oframe_data_d = bus.oram_data;
            oframe_addr_d = word_cnt_q;
            oframe_we_d   = 1'b1;
            oram_cs_d     = 1'b0;
            state_d       = ST_WRITE;
`ifdef JTCPS2_OBJ_EARLYEND_EN
            early_d = (&word_cnt_q[1:0]) && (bus.oram_data[15:8] == 8'hFF);
`endif
          end
        end
        ST_WRITE: begin
          if (last_word) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
          end else begin
            word_cnt_d = word_cnt_q + AW'(1);
            state_d    = ST_PACE;
          end
        end
        ST_DONE: begin
          busy_d    = 1'b0;
          oram_cs_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      word_cnt_q    <= '0;
      pace_cnt_q    <= '0;
      req_first_q   <= 1'b0;
      oram_cs_q     <= 1'b0;
      oframe_we_q   <= 1'b0;
      oframe_addr_q <= '0;
      oframe_data_q <= '0;
      obank_frame_q <= 1'b0;
      line_hit_q    <= 1'b0;
      busy_q        <= 1'b0;
      bank_q        <= '0;
`ifdef JTCPS2_OBJ_EARLYEND_EN
      early_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      pace_cnt_q    <= pace_cnt_d;
      req_first_q   <= req_first_d;
      oram_cs_q     <= oram_cs_d;
      oframe_we_q   <= oframe_we_d;
      oframe_addr_q <= oframe_addr_d;
      oframe_data_q <= oframe_data_d;
      obank_frame_q <= obank_frame_d;
      line_hit_q    <= line_hit_d;
      busy_q        <= busy_d;
      bank_q        <= bank_d;
`ifdef JTCPS2_OBJ_EARLYEND_EN
      early_q       <= early_d;
`endif
    end
  end

  assign bus.oram_addr   = {bank_q, word_cnt_q};
  assign bus.oram_cs     = oram_cs_q;
  assign bus.oframe_addr = oframe_addr_q;
  assign bus.oframe_data = oframe_data_q;
  assign bus.oframe_we   = oframe_we_q;
  assign obank_frame     = obank_frame_q;
  assign busy            = busy_q;

endmodule
